// File: rtl/imem_program_writer.sv
// Encodes symbolic instruction requests into 32-bit MIPS-style words and writes them
// sequentially into instruction memory, appending a NOP terminator; holds the CPU meanwhile.
module imem_program_writer #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err_illegal,
    output logic              cpu_hold
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    // Last slot of the area belongs to the terminator.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TERM, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        handshake;
    logic        op_legal;
    logic [31:0] enc_word;

    always_comb begin
        op_legal = 1'b1;
        enc_word = {6'd0, req_rs, req_rt, req_rd, 11'd0};
        case (req_op)
            3'd0: enc_word[31:26] = 6'd1;
            3'd1: enc_word[31:26] = 6'd3;
            3'd2: enc_word[31:26] = 6'd5;
            3'd3: enc_word[31:26] = 6'd7;
            3'd4: enc_word = {6'd2, req_rs, req_rt, req_imm};
            3'd5: enc_word = {6'd4, req_rs, req_rt, req_imm};
            default: begin
                op_legal = 1'b0;
                enc_word = 32'h0;
            end
        endcase
    end

    assign full      = (state_q == S_LOAD || state_q == S_TERM) && (ptr_q == LAST);
    assign req_ready = (state_q == S_LOAD) && !full && !finish && !reset;
    assign handshake = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = BASE;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    if (op_legal) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        cnt_d   = cnt_q + (ADDR_W+1)'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (finish) state_d = S_TERM;
            end
            S_TERM: begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = 32'h0;
                ptr_d   = ptr_q + ADDR_W'(1);
                cnt_d   = cnt_q + (ADDR_W+1)'(1);
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Reset masks a write already registered, so it never reaches memory.
    assign mem_we      = we_q && !reset;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign word_count  = cnt_q;
    assign busy        = (state_q == S_LOAD) || (state_q == S_TERM);
    assign done        = (state_q == S_DONE);
    assign err_illegal = err_q;
    assign cpu_hold    = (state_q != S_DONE) || reset;
endmodule

// File: tb/tb_imem_program_writer.sv
// Directed bench for imem_program_writer with a 4-word area to exercise the full boundary.
module tb_imem_program_writer;
    logic        clk = 1'b0;
    logic        reset, start, finish, req_valid, req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_imm;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_count;
    logic        busy, done, full, err_illegal, cpu_hold;
    int checks = 0;
    int errors = 0;

    imem_program_writer #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .busy(busy), .done(done), .full(full),
        .err_illegal(err_illegal), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm);
        req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
    endtask

    task automatic pulse_start;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 0; finish = 0; req_valid = 0;
        req_op = 0; req_rs = 0; req_rt = 0; req_rd = 0; req_imm = 0;
        tick(); tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, word_count} !== {1'b0, 8'd0, 32'h0, 9'd0}) begin
            errors++; $display("FAIL reset_mem we=%0b addr=%0d wdata=%h cnt=%0d want 0/0/0/0", mem_we, mem_addr, mem_wdata, word_count);
        end
        checks++;
        if ({busy, done, full, err_illegal, req_ready, cpu_hold} !== 6'b000001) begin
            errors++; $display("FAIL reset_flags got %b want 000001", {busy, done, full, err_illegal, req_ready, cpu_hold});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        pulse_start();
        checks++;
        if ({busy, req_ready, cpu_hold} !== 3'b111) begin
            errors++; $display("FAIL basic_load busy/ready/hold=%b want 111", {busy, req_ready, cpu_hold});
        end
        set_req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
        tick(); req_valid = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd0, 32'h04221800}) begin
            errors++; $display("FAIL basic_add we=%0b addr=%0d wdata=%h want 1/0/04221800", mem_we, mem_addr, mem_wdata);
        end
        finish = 1'b1; tick(); finish = 1'b0;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL basic_gap we=%0b want 0", mem_we);
        end
        tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, word_count, done, cpu_hold} !== {1'b1, 8'd1, 32'h0, 9'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL basic_term we=%0b addr=%0d wdata=%h cnt=%0d done=%0b hold=%0b want 1/1/0/2/1/0",
                               mem_we, mem_addr, mem_wdata, word_count, done, cpu_hold);
        end
        tick();
        checks++;
        if (mem_we !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL basic_idle_done we=%0b done=%0b want 0/1", mem_we, done);
        end
    endtask

    task automatic test_restart_and_back_to_back;
        pulse_start();
        checks++;
        if ({word_count, done, busy, cpu_hold} !== {9'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL restart cnt=%0d done=%0b busy=%0b hold=%0b want 0/0/1/1", word_count, done, busy, cpu_hold);
        end
        set_req(3'd4, 5'd4, 5'd5, 5'd0, 16'h0010);
        tick();
        set_req(3'd5, 5'd4, 5'd6, 5'd0, 16'hFFFC);
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd0, 32'h08850010}) begin
            errors++; $display("FAIL b2b_lw we=%0b addr=%0d wdata=%h want 1/0/08850010", mem_we, mem_addr, mem_wdata);
        end
        tick(); req_valid = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, word_count} !== {1'b1, 8'd1, 32'h1086FFFC, 9'd2}) begin
            errors++; $display("FAIL b2b_sw we=%0b addr=%0d wdata=%h cnt=%0d want 1/1/1086fffc/2", mem_we, mem_addr, mem_wdata, word_count);
        end
        finish = 1'b1; tick(); finish = 1'b0; tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, word_count} !== {1'b1, 8'd2, 32'h0, 9'd3}) begin
            errors++; $display("FAIL b2b_term we=%0b addr=%0d wdata=%h cnt=%0d want 1/2/0/3", mem_we, mem_addr, mem_wdata, word_count);
        end
    endtask

    task automatic test_illegal;
        pulse_start();
        set_req(3'd6, 5'd9, 5'd9, 5'd9, 16'h1234);
        tick();
        checks++;
        if ({mem_we, err_illegal, word_count} !== {1'b0, 1'b1, 9'd0}) begin
            errors++; $display("FAIL illegal we=%0b err=%0b cnt=%0d want 0/1/0", mem_we, err_illegal, word_count);
        end
        set_req(3'd3, 5'd0, 5'd0, 5'd31, 16'h0);
        tick(); req_valid = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, err_illegal} !== {1'b1, 8'd0, 32'h1C00F800, 1'b1}) begin
            errors++; $display("FAIL illegal_or we=%0b addr=%0d wdata=%h err=%0b want 1/0/1c00f800/1", mem_we, mem_addr, mem_wdata, err_illegal);
        end
        finish = 1'b1; tick(); finish = 1'b0; tick();
        pulse_start();
        checks++;
        if (err_illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_clear err=%0b want 0", err_illegal);
        end
        finish = 1'b1; tick(); finish = 1'b0; tick();
    endtask

    task automatic test_full;
        int writes = 0;
        logic [7:0] exp_addr = 8'd0;
        pulse_start();
        set_req(3'd2, 5'd1, 5'd1, 5'd1, 16'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_we === 1'b1) begin
                checks++;
                if (mem_addr !== exp_addr || mem_wdata !== 32'h14210800) begin
                    errors++; $display("FAIL full_write addr=%0d wdata=%h want %0d/14210800", mem_addr, mem_wdata, exp_addr);
                end
                exp_addr++;
                writes++;
            end
        end
        checks++;
        if (writes != 3 || full !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL full_stall writes=%0d full=%0b ready=%0b want 3/1/0", writes, full, req_ready);
        end
        req_valid = 1'b0;
        finish = 1'b1; tick(); finish = 1'b0; tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, word_count} !== {1'b1, 8'd3, 32'h0, 9'd4}) begin
            errors++; $display("FAIL full_term we=%0b addr=%0d wdata=%h cnt=%0d want 1/3/0/4", mem_we, mem_addr, mem_wdata, word_count);
        end
    endtask

    task automatic test_reset_mid;
        pulse_start();
        set_req(3'd0, 5'd7, 5'd7, 5'd7, 16'h0);
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({mem_we, busy, done, cpu_hold, word_count} !== {1'b0, 1'b0, 1'b0, 1'b1, 9'd0}) begin
            errors++; $display("FAIL mid_reset we=%0b busy=%0b done=%0b hold=%0b cnt=%0d want 0/0/0/1/0", mem_we, busy, done, cpu_hold, word_count);
        end
        tick();
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_idle we=%0b busy=%0b want 0/0", mem_we, busy);
        end
        pulse_start();
        set_req(3'd1, 5'd1, 5'd2, 5'd3, 16'h0);
        tick(); req_valid = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd0, 32'h0C221800}) begin
            errors++; $display("FAIL mid_reset_restart we=%0b addr=%0d wdata=%h want 1/0/0c221800", mem_we, mem_addr, mem_wdata);
        end
        finish = 1'b1; tick(); finish = 1'b0; tick();
    endtask

    task automatic test_finish_with_valid;
        pulse_start();
        set_req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
        tick();
        finish = 1'b1;
        set_req(3'd1, 5'd8, 5'd8, 5'd8, 16'h0);
        #1;
        checks++;
        if ({mem_we, mem_addr, req_ready} !== {1'b1, 8'd0, 1'b0}) begin
            errors++; $display("FAIL fin_req we=%0b addr=%0d ready=%0b want 1/0/0", mem_we, mem_addr, req_ready);
        end
        tick(); finish = 1'b0; req_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL fin_no_extra we=%0b want 0", mem_we);
        end
        tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, word_count, done} !== {1'b1, 8'd1, 32'h0, 9'd2, 1'b1}) begin
            errors++; $display("FAIL fin_term we=%0b addr=%0d wdata=%h cnt=%0d done=%0b want 1/1/0/2/1", mem_we, mem_addr, mem_wdata, word_count, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart_and_back_to_back();
        test_illegal();
        test_full();
        test_reset_mid();
        test_finish_with_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
